sprite_blitter: RTL and testbench

- DMA-style copy engine: moves a WxH rectangle from a palette-decoded sprite/map RAM (CharacterRam, GymMapRam) into FramebufferRam at a signed screen position.
- Optionally skips key-colour pixels and clips pixels that fall outside the 240x160 screen.
- Sits between the scene controller (issues blit commands) and the framebuffer write port.
- Sustains one pixel per clock.

---
 rtl/blit_pkg.sv | 22 ++
 rtl/blit_raster_counter.sv | 111 +++++++++++
 rtl/sprite_blitter.sv | 124 ++++++++++++
 tb/tb_sprite_blitter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared constants and types for the sprite blitter: screen geometry, key colour,
// address/colour types and the command FSM states.
package blit_pkg;

    localparam int          FB_W      = 240;
    localparam int          FB_H      = 160;
    localparam int          FB_DEPTH  = 38400;
    localparam int          ADDR_W    = 19;
    localparam logic [23:0] KEY_COLOR = 24'hFF00FF;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [23:0]       rgb_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN1,
        DRAIN2,
        DONE
    } blit_state_t;

endpackage

// File: rtl/blit_raster_counter.sv
// Raster walker for one blit: column/row counters, source row-base and read address,
// signed screen coordinates and the framebuffer row-offset accumulator.
module blit_raster_counter
    import blit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               adv_i,
    input  addr_t              src_base_i,
    input  logic [9:0]         src_stride_i,
    input  logic [8:0]         width_i,
    input  logic [7:0]         height_i,
    input  logic signed [9:0]  dst_x_i,
    input  logic signed [8:0]  dst_y_i,
    output addr_t              src_addr_o,
    output logic signed [10:0] dx_o,
    output logic signed [10:0] dy_o,
    output logic signed [19:0] fb_row_o,
    output logic               last_o
);

    localparam logic signed [19:0] ROW_STEP = 20'(FB_W);

    logic [8:0]         col_q, col_d, width_q, width_d;
    logic [7:0]         row_q, row_d, height_q, height_d;
    logic [9:0]         stride_q, stride_d;
    logic signed [10:0] dst_x_q, dst_x_d, dx_q, dx_d, dy_q, dy_d;
    addr_t              row_base_q, row_base_d, addr_q, addr_d;
    logic signed [19:0] fb_row_q, fb_row_d, dst_y_ext;
    logic               row_end;

    assign row_end    = (col_q == width_q - 9'd1);
    assign last_o     = row_end && (row_q == height_q - 8'd1);
    assign dst_y_ext  = 20'(dst_y_i);
    assign src_addr_o = addr_q;
    assign dx_o       = dx_q;
    assign dy_o       = dy_q;
    assign fb_row_o   = fb_row_q;

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        width_d    = width_q;
        height_d   = height_q;
        stride_d   = stride_q;
        dst_x_d    = dst_x_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        fb_row_d   = fb_row_q;
        if (load_i) begin
            width_d    = width_i;
            height_d   = height_i;
            stride_d   = src_stride_i;
            dst_x_d    = 11'(dst_x_i);
            col_d      = '0;
            row_d      = '0;
            row_base_d = src_base_i;
            addr_d     = src_base_i;
            dx_d       = 11'(dst_x_i);
            dy_d       = 11'(dst_y_i);
            // dst_y * 240 by shift-and-subtract; later rows only ever add FB_W
            fb_row_d   = (dst_y_ext <<< 8) - (dst_y_ext <<< 4);
        end else if (adv_i) begin
            if (row_end) begin
                col_d      = '0;
                row_d      = row_q + 8'd1;
                row_base_d = row_base_q + addr_t'(stride_q);
                addr_d     = row_base_d;
                dx_d       = dst_x_q;
                dy_d       = dy_q + 11'sd1;
                fb_row_d   = fb_row_q + ROW_STEP;
            end else begin
                col_d  = col_q + 9'd1;
                addr_d = addr_q + addr_t'(1);
                dx_d   = dx_q + 11'sd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            width_q    <= '0;
            height_q   <= '0;
            stride_q   <= '0;
            dst_x_q    <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            fb_row_q   <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            width_q    <= width_d;
            height_q   <= height_d;
            stride_q   <= stride_d;
            dst_x_q    <= dst_x_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            fb_row_q   <= fb_row_d;
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Rectangle copy engine: source read -> clip/key gate -> framebuffer write, one pixel
// per clock.  state | meaning: IDLE wait start | RUN issue reads | DRAIN1/2 flush pipe | DONE pulse
module sprite_blitter
    import blit_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_h,
    input  logic              start,
    input  addr_t             src_base,
    input  logic [9:0]        src_stride,
    input  logic [8:0]        width,
    input  logic [7:0]        height,
    input  logic signed [9:0] dst_x,
    input  logic signed [8:0] dst_y,
    input  logic              key_en,
    output addr_t             src_read_address,
    input  rgb_t              src_data,
    output addr_t             fb_write_address,
    output rgb_t              fb_data_In,
    output logic              fb_we,
    output logic              busy,
    output logic              done
);

    localparam logic signed [10:0] FB_W_S = 11'(FB_W);
    localparam logic signed [10:0] FB_H_S = 11'(FB_H);

    blit_state_t        state_q, state_d;
    logic               load, adv, last;
    logic               key_en_q, key_en_d;
    logic signed [10:0] dx, dy;
    logic signed [19:0] fb_row;
    logic               s1_valid_q, s1_valid_d, s1_inb_q, s1_inb_d;
    addr_t              s1_addr_q, s1_addr_d;
    logic               wr;
    logic               fb_we_q, fb_we_d;
    addr_t              fb_addr_q, fb_addr_d;
    rgb_t               fb_data_q, fb_data_d;

    blit_raster_counter u_raster (
        .clk          (Clk),
        .rst          (Reset_h),
        .load_i       (load),
        .adv_i        (adv),
        .src_base_i   (src_base),
        .src_stride_i (src_stride),
        .width_i      (width),
        .height_i     (height),
        .dst_x_i      (dst_x),
        .dst_y_i      (dst_y),
        .src_addr_o   (src_read_address),
        .dx_o         (dx),
        .dy_o         (dy),
        .fb_row_o     (fb_row),
        .last_o       (last)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (width == '0 || height == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        load    = 1'b1;
                    end
                end
            end
            RUN: begin
                if (last) state_d = DRAIN1;
                else      adv     = 1'b1;
            end
            DRAIN1:  state_d = DRAIN2;
            DRAIN2:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage 1 carries the pixel whose address is on the bus; stage 2 meets its data.
    always_comb begin
        key_en_d   = load ? key_en : key_en_q;
        s1_valid_d = (state_q == RUN);
        s1_inb_d   = (dx >= 0) && (dx < FB_W_S) && (dy >= 0) && (dy < FB_H_S);
        s1_addr_d  = addr_t'(fb_row + 20'(dx));
        wr         = s1_valid_q && s1_inb_q && !(key_en_q && (src_data == KEY_COLOR));
        fb_we_d    = wr;
        fb_addr_d  = wr ? s1_addr_q : fb_addr_q;
        fb_data_d  = wr ? src_data  : fb_data_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state_q    <= IDLE;
            key_en_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_inb_q   <= 1'b0;
            s1_addr_q  <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            key_en_q   <= key_en_d;
            s1_valid_q <= s1_valid_d;
            s1_inb_q   <= s1_inb_d;
            s1_addr_q  <= s1_addr_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end

    assign fb_we            = fb_we_q;
    assign fb_write_address = fb_addr_q;
    assign fb_data_In       = fb_data_q;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a per-command model builds the expected read and
// write schedule from pixel coordinates, and one process compares it every cycle.
module tb_sprite_blitter;

    localparam logic [23:0] KEY  = 24'hFF00FF;
    localparam int          MAXC = 64;

    logic               Clk;
    logic               Reset_h;
    logic               start;
    logic [18:0]        src_base;
    logic [9:0]         src_stride;
    logic [8:0]         width;
    logic [7:0]         height;
    logic signed [9:0]  dst_x;
    logic signed [8:0]  dst_y;
    logic               key_en;
    logic [18:0]        src_read_address;
    logic [23:0]        src_data;
    logic [18:0]        fb_write_address;
    logic [23:0]        fb_data_In;
    logic               fb_we;
    logic               busy;
    logic               done;

    sprite_blitter dut (
        .Clk              (Clk),
        .Reset_h          (Reset_h),
        .start            (start),
        .src_base         (src_base),
        .src_stride       (src_stride),
        .width            (width),
        .height           (height),
        .dst_x            (dst_x),
        .dst_y            (dst_y),
        .key_en           (key_en),
        .src_read_address (src_read_address),
        .src_data         (src_data),
        .fb_write_address (fb_write_address),
        .fb_data_In       (fb_data_In),
        .fb_we            (fb_we),
        .busy             (busy),
        .done             (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Source RAM: one-cycle read latency, contents {5'd0, addr} except one key pixel.
    bit          key_on   = 1'b0;
    logic [18:0] key_addr = '0;

    function automatic logic [23:0] src_fn(input logic [18:0] a);
        if (key_on && a == key_addr) return KEY;
        return {5'd0, a};
    endfunction

    always @(posedge Clk) src_data <= src_fn(src_read_address);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Expected schedule, indexed by cycle number relative to the accepting edge.
    logic        exp_we [MAXC];
    logic [18:0] exp_wa [MAXC];
    logic [23:0] exp_wd [MAXC];
    logic [18:0] exp_rd [MAXC];
    int          exp_n, done_c, rst_c, c_end, t0, nwr_model;
    bit          active = 1'b0;
    int          nwr_dut, ndone_dut;
    logic [18:0] hold_wa = '0;
    logic [23:0] hold_wd = '0;

    task automatic build_model(input int base, input int stride, input int w, input int h,
                               input int x0, input int y0, input bit ken);
        int          k, x, y;
        logic [18:0] a;
        logic [23:0] d;
        for (int i = 0; i < MAXC; i++) begin
            exp_we[i] = 1'b0; exp_wa[i] = '0; exp_wd[i] = '0; exp_rd[i] = '0;
        end
        exp_n     = w * h;
        nwr_model = 0;
        done_c    = (exp_n == 0) ? 1 : exp_n + 3;
        for (int r = 0; r < h; r++) begin
            for (int cc = 0; cc < w; cc++) begin
                k = r * w + cc;
                a = 19'(base + r * stride + cc);
                exp_rd[k + 1] = a;
                x = x0 + cc;
                y = y0 + r;
                d = src_fn(a);
                if (x >= 0 && x < 240 && y >= 0 && y < 160 && !(ken && d == KEY)) begin
                    exp_we[k + 3] = 1'b1;
                    exp_wa[k + 3] = 19'(y * 240 + x);
                    exp_wd[k + 3] = d;
                    nwr_model++;
                end
            end
        end
    endtask

    always @(posedge Clk) begin
        int c;
        #1;
        if (active) begin
            c = cyc - t0;
            if (c >= 1 && c <= c_end && c < MAXC) begin
                if (rst_c != 0 && c > rst_c) begin
                    hold_wa = '0;
                    hold_wd = '0;
                    chk("busy_after_reset", busy, 0);
                    chk("done_after_reset", done, 0);
                    chk("we_after_reset", fb_we, 0);
                    chk("waddr_after_reset", fb_write_address, 0);
                    chk("wdata_after_reset", fb_data_In, 0);
                    if (c == rst_c + 1) chk("raddr_after_reset", src_read_address, 0);
                end else begin
                    chk("busy", busy, (c <= done_c));
                    chk("done", done, (c == done_c));
                    chk("fb_we", fb_we, exp_we[c]);
                    if (exp_we[c]) begin
                        hold_wa = exp_wa[c];
                        hold_wd = exp_wd[c];
                    end
                    chk("fb_write_address", fb_write_address, hold_wa);
                    chk("fb_data_In", fb_data_In, hold_wd);
                    if (c <= exp_n) chk("src_read_address", src_read_address, exp_rd[c]);
                    else if (exp_n > 0) chk("src_addr_hold", src_read_address, exp_rd[exp_n]);
                end
                if (fb_we) nwr_dut++;
                if (done)  ndone_dut++;
            end
        end
    end

    // Must be entered on a falling edge; returns on the falling edge of the last checked cycle.
    task automatic run_cmd(input int base, input int stride, input int w, input int h,
                           input int x, input int y, input bit ken, input bit kon,
                           input int kaddr, input int extra, input bit busy_start,
                           input int rst_at);
        int exp_nwr, exp_ndone;
        key_on   = kon;
        key_addr = 19'(kaddr);
        build_model(base, stride, w, h, x, y, ken);
        rst_c     = rst_at;
        c_end     = done_c + extra;
        exp_nwr   = 0;
        for (int c = 1; c <= c_end && c < MAXC; c++)
            if (exp_we[c] && (rst_at == 0 || c <= rst_at)) exp_nwr++;
        exp_ndone = (rst_at == 0 || done_c <= rst_at) ? 1 : 0;
        nwr_dut   = 0;
        ndone_dut = 0;
        src_base   = 19'(base);
        src_stride = 10'(stride);
        width      = 9'(w);
        height     = 8'(h);
        dst_x      = 10'(x);
        dst_y      = 9'(y);
        key_en     = ken;
        start      = 1'b1;
        t0         = cyc;
        active     = 1'b1;
        for (int c = 1; c <= c_end; c++) begin
            @(negedge Clk);
            if (c == 1) begin
                start      = 1'b0;
                src_base   = 19'h5A5A5;
                src_stride = 10'd999;
                width      = 9'd7;
                height     = 8'd3;
                dst_x      = 10'sd5;
                dst_y      = 9'sd5;
                key_en     = !ken;
            end
            if (busy_start && c == 2) start = 1'b1;
            if (busy_start && c == 3) start = 1'b0;
            if (rst_at != 0 && c == rst_at)     Reset_h = 1'b1;
            if (rst_at != 0 && c == rst_at + 1) Reset_h = 1'b0;
        end
        chk("write_count", nwr_dut, exp_nwr);
        chk("done_count", ndone_dut, exp_ndone);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_h = 1'b1; start = 1'b0; src_base = '0; src_stride = '0; width = '0;
        height = '0; dst_x = '0; dst_y = '0; key_en = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_h = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_we", fb_we, 0);
        chk("reset_raddr", src_read_address, 0);
        chk("reset_waddr", fb_write_address, 0);
        chk("reset_wdata", fb_data_In, 0);
        @(negedge Clk);

        // Basic 2x2 copy: model pinned to hand-derived schedule
        key_on = 1'b0;
        build_model(0, 4, 2, 2, 0, 0, 1'b0);
        chk("pin_basic_rd1", exp_rd[1], 0);   chk("pin_basic_rd2", exp_rd[2], 1);
        chk("pin_basic_rd3", exp_rd[3], 4);   chk("pin_basic_rd4", exp_rd[4], 5);
        chk("pin_basic_wa3", exp_wa[3], 0);   chk("pin_basic_wa4", exp_wa[4], 1);
        chk("pin_basic_wa5", exp_wa[5], 240); chk("pin_basic_wa6", exp_wa[6], 241);
        chk("pin_basic_wd5", exp_wd[5], 4);   chk("pin_basic_wd6", exp_wd[6], 5);
        chk("pin_basic_done", done_c, 7);
        run_cmd(0, 4, 2, 2, 0, 0, 1'b0, 1'b0, 0, 3, 1'b0, 0);

        // Key colour on pixel 1, skipping enabled then disabled
        key_on = 1'b1; key_addr = 19'd1;
        build_model(0, 4, 2, 2, 0, 0, 1'b1);
        chk("pin_key_nwr", nwr_model, 3);
        chk("pin_key_skip", exp_we[4], 0);
        run_cmd(0, 4, 2, 2, 0, 0, 1'b1, 1'b1, 1, 3, 1'b0, 0);
        build_model(0, 4, 2, 2, 0, 0, 1'b0);
        chk("pin_nokey_nwr", nwr_model, 4);
        chk("pin_nokey_wd", exp_wd[4], 24'hFF00FF);
        run_cmd(0, 4, 2, 2, 0, 0, 1'b0, 1'b1, 1, 3, 1'b0, 0);

        // Left clip
        key_on = 1'b0;
        build_model(0, 4, 3, 1, -1, 0, 1'b0);
        chk("pin_clipl_nwr", nwr_model, 2);
        chk("pin_clipl_wa4", exp_wa[4], 0); chk("pin_clipl_wd4", exp_wd[4], 1);
        chk("pin_clipl_wa5", exp_wa[5], 1); chk("pin_clipl_wd5", exp_wd[5], 2);
        chk("pin_clipl_done", done_c, 6);
        run_cmd(0, 4, 3, 1, -1, 0, 1'b0, 1'b0, 0, 3, 1'b0, 0);

        // Bottom-right corner clip
        build_model(100, 10, 2, 2, 239, 159, 1'b0);
        chk("pin_corner_nwr", nwr_model, 1);
        chk("pin_corner_wa", exp_wa[3], 38399);
        chk("pin_corner_done", done_c, 7);
        run_cmd(100, 10, 2, 2, 239, 159, 1'b0, 1'b0, 0, 3, 1'b0, 0);

        // Zero-size commands
        build_model(0, 4, 0, 5, 0, 0, 1'b0);
        chk("pin_zero_done", done_c, 1);
        run_cmd(0, 4, 0, 5, 0, 0, 1'b0, 1'b0, 0, 3, 1'b0, 0);
        run_cmd(0, 4, 5, 0, 0, 0, 1'b0, 1'b0, 0, 3, 1'b0, 0);

        // Source address wraps modulo 2^19
        build_model(19'h7FFFE, 2, 3, 2, 50, 50, 1'b0);
        chk("pin_wrap_rd3", exp_rd[3], 0);
        chk("pin_wrap_rd6", exp_rd[6], 2);
        run_cmd(19'h7FFFE, 2, 3, 2, 50, 50, 1'b0, 1'b0, 0, 2, 1'b0, 0);

        // Start while busy ignored, then start in the cycle right after DONE
        run_cmd(8, 16, 4, 4, 10, 20, 1'b0, 1'b0, 0, 1, 1'b1, 0);
        run_cmd(3, 5, 3, 2, -2, 158, 1'b1, 1'b1, 10, 3, 1'b0, 0);

        // Reset in cycle 5 of a 4x4 blit, then a clean command
        run_cmd(0, 4, 4, 4, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 5);
        run_cmd(40, 20, 2, 3, 100, 100, 1'b0, 1'b0, 0, 2, 1'b0, 0);

        active = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
